// File: rtl/fir_sample_feeder.sv
// Buffers upstream samples and emits one per DIV-cycle strobe; outputs registered, one cycle after the prescaler hits DIV-1.
// Upstream is stalled by oInReady when the FIFO is full; an empty FIFO at a strobe yields a zero sample and a sticky underrun.
module fir_sample_feeder #(
  parameter int DATA_W = 3,
  parameter int DIV    = 20,
  parameter int DEPTH  = 4,
  parameter int PRIME  = 2
) (
  input  logic                       iClk12M,
  input  logic                       iRst,
  input  logic                       iEnable,
  input  logic                       iInValid,
  input  logic [DATA_W-1:0]          iInData,
  output logic                       oInReady,
  input  logic                       iClrErr,
  output logic                       oEnSample600k,
  output logic                       oEnDelay,
  output logic [DATA_W-1:0]          oFirIn,
  output logic                       oUnderrun,
  output logic [$clog2(DEPTH):0]     oFifoLevel
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DIV);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              en_q, en_d;
  logic [DATA_W-1:0] fir_q, fir_d;
  logic              under_q, under_d;

  logic tick, push, pop, empty;

  assign empty    = (level_q == '0);
  assign oInReady = (level_q != LW'(DEPTH));
  assign tick     = (state_q == S_RUN) && (presc_q == PW'(DIV - 1));
  assign push     = iInValid && oInReady;
  // A same-cycle push never rescues an empty FIFO: pop looks only at the registered level.
  assign pop      = tick && !empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iEnable) state_d = S_PRIME;
      S_PRIME: begin
        if (!iEnable)                    state_d = S_IDLE;
        else if (level_q >= LW'(PRIME))  state_d = S_RUN;
      end
      S_RUN:   if (!iEnable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    presc_d = '0;
    if (state_q == S_RUN && state_d == S_RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    en_d    = tick;
    fir_d   = fir_q;
    under_d = under_q;
    if (tick) fir_d = empty ? '0 : mem_q[rd_ptr_q];
    if (iClrErr) under_d = 1'b0;
    if (tick && empty) under_d = 1'b1;
  end

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      en_q     <= 1'b0;
      fir_q    <= '0;
      under_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      en_q     <= en_d;
      fir_q    <= fir_d;
      under_q  <= under_d;
    end
  end

  always_ff @(posedge iClk12M) begin
    if (push) mem_q[wr_ptr_q] <= iInData;
  end

  assign oEnSample600k = en_q;
  assign oEnDelay      = en_q;
  assign oFirIn        = fir_q;
  assign oUnderrun     = under_q;
  assign oFifoLevel    = level_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder: priming, strobe spacing, full/empty FIFO edges, underrun and async reset.
module tb_fir_sample_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_vld;
  logic [2:0] in_dat;
  logic       in_rdy;
  logic       clr;
  logic       strobe;
  logic       en_delay;
  logic [2:0] fir;
  logic       under;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;
  int n;
  int strobes;

  always #5 clk = ~clk;

  fir_sample_feeder #(.DATA_W(3), .DIV(20), .DEPTH(4), .PRIME(2)) dut (
    .iClk12M(clk), .iRst(rst), .iEnable(en), .iInValid(in_vld), .iInData(in_dat),
    .oInReady(in_rdy), .iClrErr(clr), .oEnSample600k(strobe), .oEnDelay(en_delay),
    .oFirIn(fir), .oUnderrun(under), .oFifoLevel(level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until a strobe is visible (bounded); n = cycles taken, 100 on timeout.
  task automatic wait_strobe(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
      chk("delay_eq_strobe", {31'b0, en_delay}, {31'b0, strobe});
    end while (!strobe && cnt < 100);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_vld = 1'b0; in_dat = 3'd0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_strobe", {31'b0, strobe}, 0);
    chk("rst_delay",  {31'b0, en_delay}, 0);
    chk("rst_fir",    {29'b0, fir}, 0);
    chk("rst_under",  {31'b0, under}, 0);
    chk("rst_ready",  {31'b0, in_rdy}, 1);
    chk("rst_level",  {29'b0, level}, 0);
    rst = 1'b0;
    step();

    // Prime with 1,2,3; RUN is entered on the edge that pushes 3.
    en = 1'b1; in_vld = 1'b1; in_dat = 3'd1; step();
    in_dat = 3'd2; step();
    in_dat = 3'd3; step();
    in_vld = 1'b0;
    wait_strobe(n);
    chk("t1_gap0", n, 20); chk("t1_fir0", {29'b0, fir}, 1); chk("t1_lvl0", {29'b0, level}, 2);
    step();
    chk("t1_single", {31'b0, strobe}, 0); chk("t1_hold", {29'b0, fir}, 1);
    wait_strobe(n);
    chk("t1_gap1", n, 19); chk("t1_fir1", {29'b0, fir}, 2);
    wait_strobe(n);
    chk("t1_gap2", n, 20); chk("t1_fir2", {29'b0, fir}, 3);
    en = 1'b0; step();

    // IDLE: fill the FIFO; values 5 and 6 must be refused.
    strobes = 0;
    in_vld = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      in_dat = 3'(k);
      step();
      if (strobe) strobes++;
    end
    in_vld = 1'b0;
    chk("t2_level", {29'b0, level}, 4);
    chk("t2_ready", {31'b0, in_rdy}, 0);
    chk("t2_nostrobe", strobes, 0);

    // Full FIFO in RUN: first tick pops only, next tick pops and pushes 7.
    en = 1'b1;
    wait_strobe(n);
    chk("t4_gap0", n, 22); chk("t4_fir0", {29'b0, fir}, 1);
    chk("t4_lvl0", {29'b0, level}, 3); chk("t4_rdy0", {31'b0, in_rdy}, 1);
    repeat (19) step();
    in_vld = 1'b1; in_dat = 3'd7;
    step();
    in_vld = 1'b0;
    chk("t4_pp_strobe", {31'b0, strobe}, 1); chk("t4_pp_fir", {29'b0, fir}, 2);
    chk("t4_pp_lvl", {29'b0, level}, 3);
    wait_strobe(n); chk("t4_gap2", n, 20); chk("t4_fir2", {29'b0, fir}, 3);
    wait_strobe(n); chk("t4_gap3", n, 20); chk("t4_fir3", {29'b0, fir}, 4);
    wait_strobe(n); chk("t4_gap4", n, 20); chk("t4_fir4", {29'b0, fir}, 7);
    chk("t4_lvl4", {29'b0, level}, 0); chk("t4_under_clear", {31'b0, under}, 0);

    // Empty tick: zero sample and sticky underrun; clear; set wins over clear.
    wait_strobe(n);
    chk("t3_gap", n, 20); chk("t3_fir", {29'b0, fir}, 0);
    chk("t3_under", {31'b0, under}, 1); chk("t3_delay", {31'b0, en_delay}, 1);
    step();
    chk("t3_off", {31'b0, strobe}, 0); chk("t3_sticky", {31'b0, under}, 1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t3_clr", {31'b0, under}, 0);
    repeat (17) step();
    clr = 1'b1; step(); clr = 1'b0;
    chk("t3_setwin_strobe", {31'b0, strobe}, 1);
    chk("t3_setwin", {31'b0, under}, 1);

    // Drop iEnable at prescaler 10; FIFO retained; re-enable restarts timing.
    in_vld = 1'b1; in_dat = 3'd1; step();
    in_dat = 3'd2; step();
    in_dat = 3'd3; step();
    in_vld = 1'b0;
    repeat (7) step();
    chk("t5_lvl_pre", {29'b0, level}, 3);
    en = 1'b0;
    strobes = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (strobe) strobes++;
    end
    chk("t5_nostrobe", strobes, 0);
    chk("t5_retained", {29'b0, level}, 3);
    en = 1'b1;
    wait_strobe(n);
    chk("t5_gap", n, 22); chk("t5_fir", {29'b0, fir}, 1); chk("t5_lvl", {29'b0, level}, 2);

    // Async reset mid-RUN with level 3.
    in_vld = 1'b1; in_dat = 3'd5; step(); in_vld = 1'b0;
    chk("t6_lvl_pre", {29'b0, level}, 3);
    #3 rst = 1'b1;
    #1;
    chk("t6_fir", {29'b0, fir}, 0);
    chk("t6_under", {31'b0, under}, 0);
    chk("t6_level", {29'b0, level}, 0);
    chk("t6_ready", {31'b0, in_rdy}, 1);
    chk("t6_strobe", {31'b0, strobe}, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();
    chk("t6_rel_level", {29'b0, level}, 0);
    chk("t6_rel_ready", {31'b0, in_rdy}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_sample_feeder.md
Name: fir_sample_feeder

Overview:
- Producer side of the FIR delay-chain sample interface.
- Accepts 3-bit signed samples from upstream over a valid/ready handshake and buffers them in a small FIFO.
- Generates the 600 kHz sample strobe from the 12 MHz clock and presents exactly one sample per strobe: oFirIn with oEnDelay, coincident with oEnSample600k.
- Inserts zero samples on underrun and reports the underrun with a sticky flag.

Parameters:
- DATA_W, 3, sample width in bits (two's complement).
- DIV, 20, clock cycles per sample strobe (12 MHz / 20 = 600 kHz); must be at least 2.
- DEPTH, 4, FIFO depth in samples; must be a power of 2.
- PRIME, 2, FIFO level required before the first strobe after leaving IDLE; 1 ≤ PRIME ≤ DEPTH.

Ports:
- iClk12M  input  1  12 MHz clock.
- iRst  input  1  asynchronous, active-high reset.
- iEnable  input  1  run request; low forces IDLE.
- iInValid  input  1  upstream sample valid.
- iInData  input  DATA_W  upstream sample.
- oInReady  output  1  FIFO can accept a sample.
- iClrErr  input  1  clears oUnderrun.
- oEnSample600k  output  1  one-cycle sample strobe.
- oEnDelay  output  1  oFirIn valid; loads the chain input.
- oFirIn  output  DATA_W  sample to the delay chain.
- oUnderrun  output  1  sticky: a zero sample was inserted.
- oFifoLevel  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE, prescaler = 0, FIFO empty (level 0, pointers 0).
  - oEnSample600k = 0, oEnDelay = 0, oFirIn = 0, oUnderrun = 0.
  - oInReady = 1.
- FIFO:
  - Push when iInValid && oInReady.
  - oInReady = (level != DEPTH), combinational from level.
  - Pop happens only on a tick in RUN.
  - Simultaneous push and pop: level unchanged. Data is written and read at distinct pointers.
  - Pointers wrap modulo DEPTH.
- State machine:
  - IDLE: prescaler held at 0; no strobes. FIFO still accepts pushes. Move to PRIME when iEnable = 1.
  - PRIME: prescaler held at 0. Move to RUN when level ≥ PRIME. Return to IDLE when iEnable = 0.
  - RUN: prescaler counts 0 to DIV-1 and wraps. A tick occurs in the cycle where prescaler == DIV-1. Move to IDLE when iEnable = 0.
  - Leaving RUN: prescaler resets to 0 and FIFO contents are retained. A tick coinciding with iEnable falling is still issued.
- Tick (all outputs registered; visible the cycle after prescaler == DIV-1):
  - oEnSample600k = 1 and oEnDelay = 1 for exactly one cycle.
  - Non-empty FIFO: oFirIn = popped head sample.
  - Empty FIFO: oFirIn = 0 and oUnderrun is set. A push in the same cycle is not usable for this tick; it is stored.
  - The first tick after entering RUN is visible DIV cycles after the PRIME→RUN transition cycle.
- oFirIn holds its value between ticks. oEnDelay and oEnSample600k are 0 outside tick cycles.
- oUnderrun:
  - Cleared by iClrErr.
  - If a set and iClrErr occur in the same cycle, set wins.
- Strobe spacing in RUN is exactly DIV cycles. It never drifts with FIFO traffic.
- Reset asserted mid-operation aborts immediately to reset values. Buffered samples are lost.

Test Plan:
- Reset, push 1, 2, 3 with iEnable = 1 (PRIME = 2) -> RUN entered once level hits 2. Strobes appear every 20 cycles with oFirIn = 1, then 2, then 3. oEnDelay is coincident with oEnSample600k on each.
- Hold iInValid = 1 with iEnable = 0 -> oInReady drops after 4 accepts; level = 4; no strobes; the 5th sample is not accepted.
- Run with level 1, no further pushes -> first tick gives the sample; the next tick gives oFirIn = 0 with oUnderrun = 1. iClrErr clears it; it sets again on the next empty tick.
- FIFO full in RUN, push attempted on the tick cycle -> pop only, level 4→3, oInReady returns to 1 the next cycle. Then push + pop in the same cycle -> level stays 3, order preserved.
- Drop iEnable mid-period (prescaler = 10) -> state goes to IDLE, no further strobes, FIFO retained. Re-enable -> first strobe 20 cycles after re-entry to RUN.
- Assert iRst during RUN with level 3 -> all outputs return to reset values immediately (async). After release, level = 0 and oInReady = 1.
